muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit that sits beside the ALU in the EX stage of the pipelined datapath. It accepts one request at a time and computes a result over DATA_W cycles, one bit per cycle. While it computes, it holds the pipeline through a stall request. It supports pipeline flush, and it completes divide-by-zero and signed-overflow cases in a single cycle.

---
 rtl/muldiv_pkg.sv | 39 +++
 rtl/muldiv_sign_fix.sv | 20 ++
 rtl/muldiv_unit.sv | 200 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types, func3 encodings and operand-signedness helpers for the
// iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // MUL low word is sign-agnostic, so it is treated as signed like MULH.
  function automatic logic op_a_signed(input logic [2:0] f3);
    case (f3)
      F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

  function automatic logic op_b_signed(input logic [2:0] f3);
    case (f3)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation: turns signed operands into
// magnitudes on the way in and restores the result sign on the way out.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] mag
);

  // negate on request, pass through otherwise
  always_comb begin
    if (negate) begin
      mag = ~value + W'(1);
    end else begin
      mag = value;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or shift-subtract step
// per cycle on operand magnitudes, with single-cycle divide special cases.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        func3,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              stall_req
);

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [2:0]          func3_r;
  logic                neg_a_r, neg_b_r;
  logic [DATA_W-1:0]   opnd_r, hi_r, lo_r, result_r;
  logic                busy_r, done_r;

  logic                neg_a_s, neg_b_s;
  logic [DATA_W-1:0]   mag_a_s, mag_b_s;
  logic                div_zero_s, ovf_s;
  logic [DATA_W-1:0]   special_res_s;
  logic [DATA_W:0]     mul_sum_s, div_shift_s;
  logic                div_ge_s;
  logic [DATA_W-1:0]   div_diff_s;
  logic [DATA_W-1:0]   hi_nx_s, lo_nx_s;
  logic [2*DATA_W-1:0] fix_in_s, fix_out_s;
  logic                fix_neg_s;
  logic [DATA_W-1:0]   calc_res_s, res_s;
  logic                accept_s, step_s, load_res_s;

  assign neg_a_s = op_a_signed(func3) & op_a[DATA_W-1];
  assign neg_b_s = op_b_signed(func3) & op_b[DATA_W-1];

  muldiv_sign_fix #(.W(DATA_W)) u_fix_a (.value(op_a), .negate(neg_a_s), .mag(mag_a_s));
  muldiv_sign_fix #(.W(DATA_W)) u_fix_b (.value(op_b), .negate(neg_b_s), .mag(mag_b_s));

  // Divide special cases resolved directly from the request operands.
  assign div_zero_s = is_div(func3) & (op_b == {DATA_W{1'b0}});
  assign ovf_s      = ((func3 == F3_DIV) | (func3 == F3_REM)) &
                      (op_a == {1'b1, {(DATA_W-1){1'b0}}}) & (op_b == {DATA_W{1'b1}});

  // quotient/remainder for divide-by-zero and signed overflow
  always_comb begin
    special_res_s = {DATA_W{1'b0}};
    if (div_zero_s) begin
      special_res_s = func3[1] ? op_a : {DATA_W{1'b1}};
    end else begin
      special_res_s = func3[1] ? {DATA_W{1'b0}} : op_a;
    end
  end

  // hi_r holds the upper product / partial remainder, lo_r the multiplier / quotient.
  assign mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(DATA_W+1){1'b0}});
  assign div_shift_s = {hi_r, lo_r[DATA_W-1]};
  assign div_ge_s    = div_shift_s >= {1'b0, opnd_r};
  assign div_diff_s  = div_shift_s[DATA_W-1:0] - opnd_r;

  // one shift-add or restoring shift-subtract step
  always_comb begin
    hi_nx_s = hi_r;
    lo_nx_s = lo_r;
    if (is_div(func3_r)) begin
      if (div_ge_s) begin
        hi_nx_s = div_diff_s;
        lo_nx_s = {lo_r[DATA_W-2:0], 1'b1};
      end else begin
        hi_nx_s = div_shift_s[DATA_W-1:0];
        lo_nx_s = {lo_r[DATA_W-2:0], 1'b0};
      end
    end else begin
      hi_nx_s = mul_sum_s[DATA_W:1];
      lo_nx_s = {mul_sum_s[0], lo_r[DATA_W-1:1]};
    end
  end

  // select the word whose sign must be restored after the final step
  always_comb begin
    fix_in_s  = {hi_nx_s, lo_nx_s};
    fix_neg_s = neg_a_r ^ neg_b_r;
    if (is_div(func3_r)) begin
      if (func3_r[1]) begin
        fix_in_s  = {{DATA_W{1'b0}}, hi_nx_s};
        fix_neg_s = neg_a_r;
      end else begin
        fix_in_s  = {{DATA_W{1'b0}}, lo_nx_s};
      end
    end else begin
      fix_in_s  = {hi_nx_s, lo_nx_s};
    end
  end

  muldiv_sign_fix #(.W(2*DATA_W)) u_fix_res (.value(fix_in_s), .negate(fix_neg_s), .mag(fix_out_s));

  assign calc_res_s = (is_div(func3_r) || (func3_r == F3_MUL)) ? fix_out_s[DATA_W-1:0]
                                                              : fix_out_s[2*DATA_W-1:DATA_W];

  // next-state, counter and datapath control
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    accept_s   = 1'b0;
    step_s     = 1'b0;
    load_res_s = 1'b0;
    res_s      = result_r;
    case (state_r)
      IDLE: begin
        if (start && !flush) begin
          if (div_zero_s || ovf_s) begin
            state_s    = DONE;
            load_res_s = 1'b1;
            res_s      = special_res_s;
          end else begin
            state_s  = CALC;
            accept_s = 1'b1;
            cnt_s    = CNT_W'(DATA_W);
          end
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (flush) begin
          state_s = IDLE;
        end else begin
          step_s = 1'b1;
          cnt_s  = cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            state_s    = DONE;
            load_res_s = 1'b1;
            res_s      = calc_res_s;
          end else begin
            state_s = CALC;
          end
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // state, counter and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      busy_r  <= (state_s == CALC);
      done_r  <= (state_s == DONE);
    end
  end

  // operand latch, accumulators and result register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      func3_r  <= 3'b000;
      neg_a_r  <= 1'b0;
      neg_b_r  <= 1'b0;
      opnd_r   <= {DATA_W{1'b0}};
      hi_r     <= {DATA_W{1'b0}};
      lo_r     <= {DATA_W{1'b0}};
      result_r <= {DATA_W{1'b0}};
    end else begin
      if (accept_s) begin
        func3_r <= func3;
        neg_a_r <= neg_a_s;
        neg_b_r <= neg_b_s;
        opnd_r  <= is_div(func3) ? mag_b_s : mag_a_s;
        hi_r    <= {DATA_W{1'b0}};
        lo_r    <= is_div(func3) ? mag_a_s : mag_b_s;
      end else if (step_s) begin
        hi_r <= hi_nx_s;
        lo_r <= lo_nx_s;
      end
      if (load_res_s) begin
        result_r <= res_s;
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign result    = result_r;
  assign stall_req = ((state_r == IDLE) & start & ~flush) | (state_r == CALC);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: transaction-level reference model
// with a per-cycle compare process, directed cases and random traffic.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset, start, flush;
  logic [2:0]        func3;
  logic [DATA_W-1:0] op_a, op_b;
  logic              busy, done, stall_req;
  logic [DATA_W-1:0] result;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          t0 = 0, done_at = -1, busy_end = -1;
  bit          pending = 1'b0;
  bit          mon_en = 1'b0;
  logic [31:0] exp_res = 32'h0, held_res = 32'h0;

  muldiv_unit #(.DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .func3(func3), .op_a(op_a), .op_b(op_b),
    .flush(flush), .busy(busy), .done(done), .result(result), .stall_req(stall_req)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Architectural RV32M results computed with plain wide arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int          ia, ib, iq;
    longint      la, lb, lp;
    logic [63:0] pb;
    bit          ovf;
    ia  = a;
    ib  = b;
    la  = ia;
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    case (f)
      F3_MUL:    begin pb = {32'h0, a} * {32'h0, b}; return pb[31:0]; end
      F3_MULH:   begin lb = ib; lp = la * lb; pb = lp; return pb[63:32]; end
      F3_MULHSU: begin lb = longint'({32'h0, b}); lp = la * lb; pb = lp; return pb[63:32]; end
      F3_MULHU:  begin pb = {32'h0, a} * {32'h0, b}; return pb[63:32]; end
      F3_DIV:    begin
        if (b == 32'h0) return 32'hFFFFFFFF;
        if (ovf) return a;
        iq = ia / ib; return iq;
      end
      F3_DIVU:   return (b == 32'h0) ? 32'hFFFFFFFF : a / b;
      F3_REM:    begin
        if (b == 32'h0) return a;
        if (ovf) return 32'h0;
        iq = ia % ib; return iq;
      end
      default:   return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 32'h0) || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  // Compare the DUT against the transaction model once per cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      bit          eb, ed, es;
      logic [31:0] er;
      eb = pending && (cyc > t0) && (cyc <= busy_end);
      ed = pending && (cyc == done_at);
      es = (pending && (cyc == t0)) || eb;
      er = (pending && done_at >= 0 && cyc >= done_at) ? exp_res : held_res;
      check("busy", {31'h0, busy}, {31'h0, eb});
      check("done", {31'h0, done}, {31'h0, ed});
      check("stall_req", {31'h0, stall_req}, {31'h0, es});
      check("result", result, er);
    end
  end

  // Issue one request at the current cycle (called #1 after a rising edge).
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; flush = 1'b0; func3 = f; op_a = a; op_b = b;
    t0 = cyc;
    exp_res = model(f, a, b);
    if (is_special(f, a, b)) begin
      done_at = cyc + 1; busy_end = cyc;
    end else begin
      done_at = cyc + DATA_W + 1; busy_end = cyc + DATA_W;
    end
    pending = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    func3 = 3'($urandom_range(0, 7)); op_a = $urandom; op_b = $urandom;
    while (cyc <= done_at) begin
      @(posedge clk); #1;
    end
    held_res = exp_res;
    pending = 1'b0;
  endtask

  logic [2:0]  d_f   [12] = '{F3_MUL, F3_MULH, F3_MULHU, F3_MULHSU, F3_DIV, F3_REM,
                              F3_DIVU, F3_REMU, F3_DIVU, F3_REM, F3_DIV, F3_REM};
  logic [31:0] d_a   [12] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                              32'hFFFFFFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
  logic [31:0] d_b   [12] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] d_exp [12] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD,
                              32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    int          sel;
    reset = 1'b1; start = 1'b0; flush = 1'b0; func3 = 3'b000; op_a = 32'h0; op_b = 32'h0;
    #3;
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_done", {31'h0, done}, 32'h0);
    check("reset_stall", {31'h0, stall_req}, 32'h0);
    check("reset_result", result, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    for (int i = 0; i < 12; i++) begin
      check($sformatf("model_pin%0d", i), model(d_f[i], d_a[i], d_b[i]), d_exp[i]);
      do_op(d_f[i], d_a[i], d_b[i]);
      check($sformatf("directed%0d", i), result, d_exp[i]);
    end

    // Flush mid-divide: result must keep the earlier 14.
    do_op(F3_DIVU, 32'd100, 32'd7);
    start = 1'b1; func3 = F3_DIVU; op_a = 32'd1000; op_b = 32'd3;
    t0 = cyc; done_at = -1; busy_end = cyc + 10; pending = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < t0 + 10) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    pending = 1'b0;
    check("flush_busy", {31'h0, busy}, 32'h0);
    check("flush_result", result, 32'd14);
    do_op(F3_DIVU, 32'd1000, 32'd3);
    check("after_flush", result, 32'd333);

    // Random traffic, back-to-back or with idle gaps.
    for (int n = 0; n < 60; n++) begin
      rf  = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'h0;
      else if (sel == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      else if (sel == 2) begin ra = $urandom_range(0, 300); rb = $urandom_range(1, 20); end
      else if (sel == 3) rb = 32'($urandom_range(0, 15)) - 32'd8;
      do_op(rf, ra, rb);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    // Asynchronous reset in cycle 15 of a multiply.
    start = 1'b1; func3 = F3_MUL; op_a = 32'd123; op_b = 32'd456;
    t0 = cyc; done_at = cyc + DATA_W + 1; busy_end = cyc + DATA_W;
    exp_res = model(F3_MUL, 32'd123, 32'd456); pending = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < t0 + 15) begin
      @(posedge clk); #1;
    end
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    check("midreset_busy", {31'h0, busy}, 32'h0);
    check("midreset_done", {31'h0, done}, 32'h0);
    check("midreset_stall", {31'h0, stall_req}, 32'h0);
    check("midreset_result", result, 32'h0);
    pending = 1'b0; held_res = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    do_op(F3_MUL, 32'd3, 32'd4);
    check("mul_after_reset", result, 32'd12);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
